// File: rtl/add_sub_pkg.sv
// -----------------------------------------------------------------------------
// add_sub_pkg
// Shared definitions for the add/subtract cell family and the digit-serial
// add/sub controller.
//   MODE_ADD / MODE_SUB : operation select encoding.
//   state_t             : controller state encoding (ST_IDLE, ST_RUN, ST_DONE).
// -----------------------------------------------------------------------------
package add_sub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_add_sub_cell.sv
// -----------------------------------------------------------------------------
// full_add_sub_cell
// One-bit combined full adder / full subtractor.
//   a, b  : operand bits (minuend/addend, subtrahend/addend)
//   c     : carry-in (add) or borrow-in (sub)
//   mode  : MODE_ADD or MODE_SUB
//   s     : sum or difference bit
//   co    : carry-out (add) or borrow-out (sub)
// -----------------------------------------------------------------------------
module full_add_sub_cell
    import add_sub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic mode,
    output logic s,
    output logic co
);

    logic w_p;

    assign w_p = a ^ b;
    assign s   = w_p ^ c;

    // Borrow propagates when the bits are equal, is generated when a=0,b=1.
    assign co = (mode == MODE_SUB) ? ((~a & b) | (c & ~w_p))
                                   : ((a & b) | (c & w_p));

endmodule

// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
// Digit-serial adder/subtractor. Operands are captured on an accepted start,
// then DIGIT bits per clock are pushed LSB-first through a ripple chain of
// full_add_sub_cell instances; the carry/borrow is held between digits.
// WIDTH must be >= 2 and a multiple of DIGIT. N = WIDTH/DIGIT cycles per op.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      new operation request, accepted in IDLE or DONE
//   op_a/op_b  operands, captured with start
//   mode       0 = add (a+b+cin), 1 = subtract (a-b-bin), captured with start
//   cin_bin    carry-in / borrow-in, captured with start
//   busy       high while the operation is running
//   done       one-cycle pulse when result/flags update
//   result     sum or difference modulo 2^WIDTH
//   cout_bout  carry out of MSB (add) or borrow out (sub)
//   overflow   signed two's-complement overflow
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start
// ST_RUN  | one digit processed per clock, N clocks total
// ST_DONE | done pulse; start here chains the next op with no idle gap
// -----------------------------------------------------------------------------
module serial_add_sub
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mode,
    input  logic             cin_bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout_bout,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res_sh;
    logic [WIDTH-1:0] r_result;
    logic             r_mode;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_last;
    logic [DIGIT:0]   w_c;
    logic [DIGIT-1:0] w_sum;
    logic [WIDTH-1:0] w_res_nxt;
    logic             w_a_msb;
    logic             w_b_msb;
    logic             w_r_msb;
    logic             w_ovf;

    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = (r_state == ST_RUN) && (r_cnt == LAST);

    // Ripple chain over the current digit.
    assign w_c[0] = r_carry;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        full_add_sub_cell u_cell (
            .a    (r_a[i]),
            .b    (r_b[i]),
            .c    (w_c[i]),
            .mode (r_mode),
            .s    (w_sum[i]),
            .co   (w_c[i+1])
        );
    end

    // New digit enters at the MSB end so that after N shifts the LSB digit
    // has walked down to bit 0. Written without part-selects so it also
    // holds for DIGIT == WIDTH.
    assign w_res_nxt = (r_res_sh >> DIGIT) | (WIDTH'(w_sum) << (WIDTH - DIGIT));

    // On the last digit the operand MSBs sit at the top of the low digit.
    assign w_a_msb = r_a[DIGIT-1];
    assign w_b_msb = r_b[DIGIT-1];
    assign w_r_msb = w_sum[DIGIT-1];
    assign w_ovf   = (r_mode == MODE_ADD)
                   ? ((w_a_msb == w_b_msb) && (w_r_msb != w_a_msb))
                   : ((w_a_msb != w_b_msb) && (w_r_msb != w_a_msb));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = w_accept ? ST_RUN : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res_sh <= '0;
            r_result <= '0;
            r_mode   <= 1'b0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a      <= op_a;
            r_b      <= op_b;
            r_mode   <= mode;
            r_carry  <= cin_bin;
            r_res_sh <= '0;
            r_cnt    <= '0;
        end else if (r_state == ST_RUN) begin
            r_a      <= r_a >> DIGIT;
            r_b      <= r_b >> DIGIT;
            r_res_sh <= w_res_nxt;
            r_carry  <= w_c[DIGIT];
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_result <= w_res_nxt;
                r_cout   <= w_c[DIGIT];
                r_ovf    <= w_ovf;
            end
        end
    end

    assign result    = r_result;
    assign cout_bout = r_cout;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_serial_add_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sub
// Four instances share clock, reset and operand buses; start is steered to one
// instance at a time. Expected results are queued at start acceptance and
// compared when that instance pulses done.
//   dut 0: WIDTH=8 DIGIT=1   dut 1: WIDTH=8 DIGIT=4
//   dut 2: WIDTH=4 DIGIT=4   dut 3: WIDTH=4 DIGIT=1
// -----------------------------------------------------------------------------
module tb_serial_add_sub;
    import add_sub_pkg::*;

    typedef struct packed {
        logic       co;
        logic       ov;
        logic [7:0] res;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    int         sel;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       mode;
    logic       cin_bin;

    logic [3:0] start_v;
    logic [3:0] busy_v;
    logic [3:0] done_v;
    logic [3:0] co_v;
    logic [3:0] ov_v;
    logic [7:0] res0;
    logic [7:0] res1;
    logic [3:0] res2;
    logic [3:0] res3;

    exp_t q [4][$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   waited;

    always #5 clk = ~clk;

    assign start_v[0] = start && (sel == 0);
    assign start_v[1] = start && (sel == 1);
    assign start_v[2] = start && (sel == 2);
    assign start_v[3] = start && (sel == 3);

    serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .op_a(op_a), .op_b(op_b),
        .mode(mode), .cin_bin(cin_bin), .busy(busy_v[0]), .done(done_v[0]),
        .result(res0), .cout_bout(co_v[0]), .overflow(ov_v[0]));

    serial_add_sub #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .op_a(op_a), .op_b(op_b),
        .mode(mode), .cin_bin(cin_bin), .busy(busy_v[1]), .done(done_v[1]),
        .result(res1), .cout_bout(co_v[1]), .overflow(ov_v[1]));

    serial_add_sub #(.WIDTH(4), .DIGIT(4)) u_w4d4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .op_a(op_a[3:0]), .op_b(op_b[3:0]),
        .mode(mode), .cin_bin(cin_bin), .busy(busy_v[2]), .done(done_v[2]),
        .result(res2), .cout_bout(co_v[2]), .overflow(ov_v[2]));

    serial_add_sub #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .op_a(op_a[3:0]), .op_b(op_b[3:0]),
        .mode(mode), .cin_bin(cin_bin), .busy(busy_v[3]), .done(done_v[3]),
        .result(res3), .cout_bout(co_v[3]), .overflow(ov_v[3]));

    function automatic logic [7:0] res_of(input int i);
        case (i)
            0:       return res0;
            1:       return res1;
            2:       return {4'h0, res2};
            default: return {4'h0, res3};
        endcase
    endfunction

    function automatic int wof(input int s);
        return (s < 2) ? 8 : 4;
    endfunction

    // Reference: plain integer arithmetic, unsigned for carry/borrow and
    // signed range test for overflow.
    function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                   input logic m, input logic c);
        int   ai, bi, ci, s, sa, sb, ss, half, full;
        exp_t e;
        full = 1 << w;
        half = 1 << (w - 1);
        ai   = int'(a) & (full - 1);
        bi   = int'(b) & (full - 1);
        ci   = int'(c);
        if (m == MODE_ADD) begin
            s    = ai + bi + ci;
            e.co = (s >= full);
        end else begin
            s    = ai - bi - ci;
            e.co = (ai < bi + ci);
        end
        e.res = 8'(s & (full - 1));
        sa    = (ai >= half) ? ai - full : ai;
        sb    = (bi >= half) ? bi - full : bi;
        ss    = (m == MODE_ADD) ? sa + sb + ci : sa - sb - ci;
        e.ov  = (ss > half - 1) || (ss < -half);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives start (held high) until the selected instance accepts it, i.e.
    // busy rises across an edge. Returns the number of edges waited.
    task automatic issue(input int s, input logic [7:0] a, input logic [7:0] b,
                         input logic m, input logic c, output int n_wait);
        bit   ok;
        logic prev;
        sel     = s;
        op_a    = a;
        op_b    = b;
        mode    = m;
        cin_bin = c;
        start   = 1'b1;
        ok      = 1'b0;
        n_wait  = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            prev = busy_v[s];
            @(posedge clk);
            #1;
            n_wait++;
            if (busy_v[s] && !prev) ok = 1'b1;
        end
        start = 1'b0;
        if (!ok) chk($sformatf("dut%0d_accept_timeout", s), 32'(ok), 32'd1);
        else     q[s].push_back(model(wof(s), a, b, m, c));
    endtask

    task automatic drain(input int s);
        for (int n = 0; n < 60 && q[s].size() != 0; n++) @(posedge clk);
        #1;
        if (q[s].size() != 0) chk($sformatf("dut%0d_done_timeout", s), 32'(q[s].size()), 32'd0);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (done_v[i] === 1'b1) begin
                if (q[i].size() == 0) begin
                    chk($sformatf("dut%0d_spurious_done", i), 32'(done_v[i]), 32'd0);
                end else begin
                    mon_e = q[i].pop_front();
                    chk($sformatf("dut%0d_co_ov_res", i),
                        32'({co_v[i], ov_v[i], res_of(i)}), 32'(mon_e));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; sel = 0;
        op_a = 8'h00; op_b = 8'h00; mode = MODE_ADD; cin_bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("dut%0d_rst_result", i), 32'(res_of(i)), 32'd0);
            chk($sformatf("dut%0d_rst_cout", i), 32'(co_v[i]), 32'd0);
            chk($sformatf("dut%0d_rst_ovf", i), 32'(ov_v[i]), 32'd0);
            chk($sformatf("dut%0d_rst_busy", i), 32'(busy_v[i]), 32'd0);
            chk($sformatf("dut%0d_rst_done", i), 32'(done_v[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 8-bit serial add with latency / pulse-width checks.
        issue(0, 8'h5A, 8'h3C, MODE_ADD, 1'b0, waited);
        for (int j = 1; j < 8; j++) begin
            @(posedge clk); #1;
            chk("w8d1_busy_in_run", 32'(busy_v[0]), 32'd1);
            chk("w8d1_no_early_done", 32'(done_v[0]), 32'd0);
        end
        @(posedge clk); #1;
        chk("w8d1_done_at_n", 32'(done_v[0]), 32'd1);
        chk("w8d1_busy_low_at_done", 32'(busy_v[0]), 32'd0);
        @(posedge clk); #1;
        chk("w8d1_done_one_cycle", 32'(done_v[0]), 32'd0);
        chk("w8d1_result_hold", 32'(res0), 32'h96);
        chk("w8d1_ovf_hold", 32'(ov_v[0]), 32'd1);
        drain(0);

        // Back-to-back subtracts: start held through DONE, no idle cycle.
        issue(0, 8'h10, 8'h20, MODE_SUB, 1'b0, waited);
        issue(0, 8'h80, 8'h01, MODE_SUB, 1'b0, waited);
        chk("w8d1_b2b_gap", 32'(waited), 32'd9);
        drain(0);

        // 8-bit, 4 bits per digit: two-cycle latency.
        issue(1, 8'hFF, 8'h01, MODE_ADD, 1'b1, waited);
        @(posedge clk); #1;
        chk("w8d4_no_early_done", 32'(done_v[1]), 32'd0);
        @(posedge clk); #1;
        chk("w8d4_done_at_2", 32'(done_v[1]), 32'd1);
        drain(1);

        // start pulsed mid-run with other operands is ignored.
        issue(0, 8'hC3, 8'h5A, MODE_ADD, 1'b1, waited);
        repeat (2) begin @(posedge clk); #1; end
        sel = 0; op_a = 8'hFF; op_b = 8'hFF; mode = MODE_SUB; cin_bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("w8d1_midrun_busy", 32'(busy_v[0]), 32'd1);
        drain(0);

        // Reset in RUN cycle 3 aborts: outputs cleared, no done.
        issue(0, 8'h33, 8'h44, MODE_SUB, 1'b1, waited);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q[0].delete();
        chk("abort_result", 32'(res0), 32'd0);
        chk("abort_cout", 32'(co_v[0]), 32'd0);
        chk("abort_busy", 32'(busy_v[0]), 32'd0);
        chk("abort_done", 32'(done_v[0]), 32'd0);
        for (int j = 0; j < 10; j++) begin
            @(posedge clk); #1;
            chk("abort_no_done", 32'(done_v[0]), 32'd0);
        end
        issue(0, 8'h5A, 8'h3C, MODE_ADD, 1'b0, waited);
        drain(0);

        // Exhaustive 4-bit, parallel and bit-serial.
        for (int s = 2; s < 4; s++) begin
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    for (int m = 0; m < 2; m++)
                        for (int c = 0; c < 2; c++)
                            issue(s, 8'(a), 8'(b), 1'(m), 1'(c), waited);
            drain(s);
        end

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            chk($sformatf("dut%0d_queue_empty", i), 32'(q[i].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
